// File: rtl/aes128_round_key_server_if.sv
// Round-key stream bundle: start/dir/key request side plus the rk valid/ready
// stream and status flags shared between the key server and its consumer.
interface aes128_round_key_server_if;
    logic         start;
    logic         dir;
    logic [127:0] key;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    modport master (
        output start, dir, key, rk_ready,
        input  rk, rk_idx, rk_valid, busy, done
    );

    modport slave (
        input  start, dir, key, rk_ready,
        output rk, rk_idx, rk_valid, busy, done
    );
endinterface

// File: rtl/aes128_round_key_server.sv
// Sequential AES-128 round-key source: K0..K10 expanded on the fly, or K10..K0 by
// winding forward to K10 and then running the inverse key-schedule recurrence.
module aes128_round_key_server #(
    parameter int unsigned NR = 10
) (
    input logic                      clk,
    input logic                      rst_n,
    aes128_round_key_server_if.slave bus
);
    localparam logic [3:0] LAST_R = 4'(NR);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, WIND, SERVE, FIN} state_e;

    state_e       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [3:0]   r_q, r_d;
    logic         dir_q, dir_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3, w3_rev;
    logic [31:0]  sub_in, sub_out, t;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] fwd_key, rev_key;
    logic [3:0]   rcon_idx;
    logic         sel_rev, last_key;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{8'd255 - b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        w0 = work_q[127:96];
        w1 = work_q[95:64];
        w2 = work_q[63:32];
        w3 = work_q[31:0];
        w3_rev = w3 ^ w2;

        // One SubWord serves both directions: reverse feeds w3' and undoes Rcon(r).
        sel_rev  = (state_q == SERVE) && dir_q;
        sub_in   = sel_rev ? {w3_rev[23:0], w3_rev[31:24]} : {w3[23:0], w3[31:24]};
        rcon_idx = sel_rev ? r_q : r_q + 4'd1;
        sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
        t        = sub_out ^ {rcon(rcon_idx), 24'h0};

        f0 = w0 ^ t;
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
        fwd_key = {f0, f1, f2, f3};
        rev_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3_rev};

        last_key = dir_q ? (r_q == 4'd0) : (r_q == LAST_R);

        state_d = state_q;
        work_d  = work_q;
        r_d     = r_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.key;
                    dir_d   = bus.dir;
                    r_d     = '0;
                    state_d = bus.dir ? WIND : SERVE;
                end
            end
            WIND: begin
                work_d = fwd_key;
                r_d    = r_q + 4'd1;
                if (r_q == LAST_R - 4'd1) state_d = SERVE;
            end
            SERVE: begin
                if (bus.rk_ready) begin
                    if (last_key) begin
                        state_d = FIN;
                    end else if (dir_q) begin
                        work_d = rev_key;
                        r_d    = r_q - 4'd1;
                    end else begin
                        work_d = fwd_key;
                        r_d    = r_q + 4'd1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rk_valid_d = (state_d == SERVE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            r_q        <= '0;
            dir_q      <= 1'b0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            r_q        <= r_d;
            dir_q      <= dir_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rk       = work_q;
    assign bus.rk_idx   = r_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_aes128_round_key_server.sv
// Bench for aes128_round_key_server: an independent FIPS-197 key expansion fills a
// scoreboard queue at each start; keys are popped as handshakes happen.
module tb_aes128_round_key_server;
    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_A   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K10_A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];
    logic [7:0]   sbox_m [256];
    logic [127:0] sched [11];

    aes128_round_key_server_if bus();

    aes128_round_key_server #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse plus affine map, independent of any table.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_expected(input logic [127:0] k, input logic d);
        exp_t e;
        expand(k);
        for (int r = 0; r < 11; r++) begin
            int idx;
            idx = d ? 10 - r : r;
            e.idx = 4'(idx);
            e.key = sched[idx];
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_start(input logic [127:0] k, input logic d);
        bus.start = 1'b1; bus.key = k; bus.dir = d;
        @(negedge clk);
        bus.start = 1'b0; bus.key = '0; bus.dir = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.rk, bus.rk_idx, bus.rk_valid, bus.busy, bus.done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_values got rk=%h idx=%0d v=%b busy=%b done=%b want all 0",
                     bus.rk, bus.rk_idx, bus.rk_valid, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_release got busy=%b v=%b want 0 0", bus.busy, bus.rk_valid);
        end
    endtask

    task automatic test_forward();
        exp_t e;
        int n;
        push_expected(KEY_A, 1'b0);
        bus.rk_ready = 1'b1;
        issue_start(KEY_A, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tests_run++;
            if (bus.rk_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL fwd_valid cyc=%0d got %b want 1", n, bus.rk_valid);
            end else begin
                e = exp_q.pop_front();
                tests_run++;
                if (bus.rk_idx !== e.idx || bus.rk !== e.key) begin
                    tests_failed++;
                    $display("FAIL fwd_key got idx=%0d rk=%h want idx=%0d rk=%h", bus.rk_idx, bus.rk, e.idx, e.key);
                end
                if (n == 0) begin
                    tests_run++;
                    if (bus.rk !== KEY_A || bus.rk_idx !== 4'd0) begin
                        tests_failed++;
                        $display("FAIL fwd_k0_latency got idx=%0d rk=%h want 0 %h", bus.rk_idx, bus.rk, KEY_A);
                    end
                end
                if (e.idx == 4'd1) begin
                    tests_run++;
                    if (bus.rk !== K1_A) begin
                        tests_failed++;
                        $display("FAIL fwd_k1 got %h want %h", bus.rk, K1_A);
                    end
                end
                if (e.idx == 4'd10) begin
                    tests_run++;
                    if (bus.rk !== K10_A || n != 10) begin
                        tests_failed++;
                        $display("FAIL fwd_k10 got rk=%h cyc=%0d want %h cyc=10", bus.rk, n, K10_A);
                    end
                end
            end
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (exp_q.size() != 0 || bus.done !== 1'b1 || bus.rk_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_done got left=%0d done=%b v=%b want 0 1 0", exp_q.size(), bus.done, bus.rk_valid);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_idle got done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        exp_q.delete();
    endtask

    task automatic test_reverse();
        exp_t e;
        int n;
        push_expected(KEY_A, 1'b1);
        bus.rk_ready = 1'b1;
        issue_start(KEY_A, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL rev_wind cyc=%0d got v=%b busy=%b want 0 1", i, bus.rk_valid, bus.busy);
            end
            @(negedge clk);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tests_run++;
            if (bus.rk_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL rev_valid cyc=%0d got %b want 1", n, bus.rk_valid);
            end else begin
                e = exp_q.pop_front();
                tests_run++;
                if (bus.rk_idx !== e.idx || bus.rk !== e.key) begin
                    tests_failed++;
                    $display("FAIL rev_key got idx=%0d rk=%h want idx=%0d rk=%h", bus.rk_idx, bus.rk, e.idx, e.key);
                end
                if (n == 0) begin
                    tests_run++;
                    if (bus.rk !== K10_A || bus.rk_idx !== 4'd10) begin
                        tests_failed++;
                        $display("FAIL rev_k10_latency got idx=%0d rk=%h want 10 %h", bus.rk_idx, bus.rk, K10_A);
                    end
                end
                if (e.idx == 4'd1) begin
                    tests_run++;
                    if (bus.rk !== K1_A) begin
                        tests_failed++;
                        $display("FAIL rev_k1 got %h want %h", bus.rk, K1_A);
                    end
                end
                if (e.idx == 4'd0) begin
                    tests_run++;
                    if (bus.rk !== KEY_A) begin
                        tests_failed++;
                        $display("FAIL rev_k0 got %h want %h", bus.rk, KEY_A);
                    end
                end
            end
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (exp_q.size() != 0 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rev_done got left=%0d done=%b want 0 1", exp_q.size(), bus.done);
        end
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int n, stalls;
        logic stalled;
        logic [127:0] hold_rk;
        logic [3:0] hold_idx;
        push_expected(KEY_A, 1'b0);
        issue_start(KEY_A, 1'b0);
        n = 0; stalls = 0; stalled = 1'b0; hold_rk = '0; hold_idx = '0;
        while (exp_q.size() != 0 && n < 300) begin
            if (stalled) begin
                tests_run++;
                if (bus.rk_valid !== 1'b1 || bus.rk !== hold_rk || bus.rk_idx !== hold_idx) begin
                    tests_failed++;
                    $display("FAIL bp_hold got v=%b idx=%0d rk=%h want 1 %0d %h",
                             bus.rk_valid, bus.rk_idx, bus.rk, hold_idx, hold_rk);
                end
            end
            bus.rk_ready = (n % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            stalled = 1'b0;
            if (bus.rk_valid === 1'b1) begin
                if (bus.rk_ready) begin
                    e = exp_q.pop_front();
                    tests_run++;
                    if (bus.rk_idx !== e.idx || bus.rk !== e.key) begin
                        tests_failed++;
                        $display("FAIL bp_key got idx=%0d rk=%h want idx=%0d rk=%h", bus.rk_idx, bus.rk, e.idx, e.key);
                    end
                end else begin
                    stalled = 1'b1; stalls++;
                    hold_rk = bus.rk; hold_idx = bus.rk_idx;
                end
            end
            n++;
            @(negedge clk);
        end
        bus.rk_ready = 1'b1;
        tests_run++;
        if (exp_q.size() != 0 || bus.done !== 1'b1 || stalls == 0) begin
            tests_failed++;
            $display("FAIL bp_done got left=%0d done=%b stalls=%0d want 0 1 >0", exp_q.size(), bus.done, stalls);
        end
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_start_while_busy();
        exp_t e;
        int n;
        push_expected(KEY_A, 1'b0);
        bus.rk_ready = 1'b1;
        issue_start(KEY_A, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            bus.start = (n == 3);
            bus.key   = (n == 3) ? KEY_B : '0;
            bus.dir   = (n == 3);
            if (bus.rk_valid === 1'b1) begin
                e = exp_q.pop_front();
                tests_run++;
                if (bus.rk_idx !== e.idx || bus.rk !== e.key) begin
                    tests_failed++;
                    $display("FAIL busy_key got idx=%0d rk=%h want idx=%0d rk=%h", bus.rk_idx, bus.rk, e.idx, e.key);
                end
            end
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0; bus.key = '0; bus.dir = 1'b0;
        tests_run++;
        if (exp_q.size() != 0 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_done got left=%0d done=%b want 0 1", exp_q.size(), bus.done);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_no_restart got busy=%b v=%b want 0 0", bus.busy, bus.rk_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n;
        push_expected(KEY_B, 1'b0);
        bus.rk_ready = 1'b1;
        issue_start(KEY_B, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            if (bus.rk_valid === 1'b1) begin
                e = exp_q.pop_front();
                tests_run++;
                if (bus.rk_idx !== e.idx || bus.rk !== e.key) begin
                    tests_failed++;
                    $display("FAIL b2b_first got idx=%0d rk=%h want idx=%0d rk=%h", bus.rk_idx, bus.rk, e.idx, e.key);
                end
            end
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done got %b want 1", bus.done);
        end
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle got busy=%b want 0", bus.busy);
        end
        exp_q.delete();
        push_expected(KEY_A, 1'b0);
        issue_start(KEY_A, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tests_run++;
            if (bus.rk_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_valid cyc=%0d got %b want 1", n, bus.rk_valid);
            end else begin
                e = exp_q.pop_front();
                tests_run++;
                if (bus.rk_idx !== e.idx || bus.rk !== e.key) begin
                    tests_failed++;
                    $display("FAIL b2b_second got idx=%0d rk=%h want idx=%0d rk=%h", bus.rk_idx, bus.rk, e.idx, e.key);
                end
            end
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (exp_q.size() != 0 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done2 got left=%0d done=%b want 0 1", exp_q.size(), bus.done);
        end
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_reset_mid_stream();
        exp_t e;
        int n, first;
        bus.rk_ready = 1'b1;
        issue_start(KEY_A, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.start = 1'b1; bus.key = KEY_B; bus.dir = 1'b0;
        #1;
        tests_run++;
        if ({bus.rk, bus.rk_idx, bus.rk_valid, bus.busy, bus.done} !== '0) begin
            tests_failed++;
            $display("FAIL rst_async got idx=%0d v=%b busy=%b done=%b rk=%h want all 0",
                     bus.rk_idx, bus.rk_valid, bus.busy, bus.done, bus.rk);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.rk, bus.rk_idx, bus.rk_valid, bus.busy, bus.done} !== '0) begin
            tests_failed++;
            $display("FAIL rst_hold got idx=%0d v=%b busy=%b done=%b want all 0",
                     bus.rk_idx, bus.rk_valid, bus.busy, bus.done);
        end
        bus.start = 1'b0; bus.key = '0;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_release got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        push_expected(KEY_B, 1'b1);
        issue_start(KEY_B, 1'b1);
        n = 0; first = -1;
        while (exp_q.size() != 0 && n < 40) begin
            if (bus.rk_valid === 1'b1) begin
                if (first < 0) first = n;
                e = exp_q.pop_front();
                tests_run++;
                if (bus.rk_idx !== e.idx || bus.rk !== e.key) begin
                    tests_failed++;
                    $display("FAIL rst_rerun got idx=%0d rk=%h want idx=%0d rk=%h", bus.rk_idx, bus.rk, e.idx, e.key);
                end
            end
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (exp_q.size() != 0 || first != 10 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_rerun_end got left=%0d first=%0d done=%b want 0 10 1", exp_q.size(), first, bus.done);
        end
        @(negedge clk);
        exp_q.delete();
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        tests_run = 0; tests_failed = 0;
        bus.start = 1'b0; bus.dir = 1'b0; bus.key = '0; bus.rk_ready = 1'b0;
        build_sbox();
        test_reset();
        test_forward();
        test_reverse();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/aes128_round_key_server.md
# aes128_round_key_server

Sequential AES-128 round-key source for the cipher datapath. It loads a 128-bit cipher key and delivers round keys K0..K10 one at a time over a valid/ready stream. In forward order (encryption) it expands keys on the fly. In reverse order (decryption) it first expands to K10, then derives K9..K0 with the inverse key-schedule recurrence, so the decryption core never needs the full 1408-bit schedule in storage.

## Interface
Parameters:
- NR, 10, number of rounds; fixed at 10 because only AES-128 is supported.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request; sampled only in IDLE.
- dir, in, 1, sampled with start: 0 = forward (K0→K10), 1 = reverse (K10→K0).
- key, in, 128, cipher key sampled with start; key[127:96] is w0, key[31:0] is w3 (FIPS-197 word order).
- rk, out, 128, current round key, same word order as key.
- rk_idx, out, 4, round number of rk (0..10).
- rk_valid, out, 1, rk/rk_idx are valid.
- rk_ready, in, 1, consumer accepts rk when rk_valid && rk_ready at a rising edge.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse after the final key is accepted.

## Operation
- States: IDLE, WIND, SERVE, FIN.
- IDLE:
  - On start, load key into the 128-bit working register, latch dir, and clear the round counter r to 0.
  - If dir=0, go to SERVE.
  - If dir=1, go to WIND.
- WIND:
  - Each cycle, apply the forward step and increment r.
  - When r reaches 10 (after 10 cycles), go to SERVE.
  - rk_valid stays 0 throughout.
- SERVE:
  - rk = working register, rk_idx = r, rk_valid = 1.
  - On handshake, if this is the last key (r=10 when dir=0, r=0 when dir=1), go to FIN. Otherwise, apply the forward step (dir=0, r+1) or the reverse step (dir=1, r−1).
- FIN: done=1 for one cycle, then IDLE. rk_valid=0.
- Forward step, producing round r+1 from round r:
  - t = SubWord(RotWord(w3)) ^ {Rcon(r+1),24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Reverse step, producing round r−1 from round r:
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon(r),24'h0}.
- RotWord: {b1,b2,b3,b0} for byte order b0 = MSB.
- Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36.
- SubWord: four parallel forward S-box lookups. One SubWord instance is shared by both steps, with the mux on its input.
- All XOR arithmetic is 32-bit. r is 4 bits and never leaves the range 0..10.

## Timing
- Reset values: rk=0, rk_idx=0, rk_valid=0, busy=0, done=0; state=IDLE, r=0.
- Reset is asynchronous at any point, including mid-WIND or mid-SERVE. It aborts the operation with no done pulse. The first start after reset release is honoured normally.
- Forward latency: start at edge t gives rk_valid=1 with K0 after edge t+1.
- Reverse latency: start at edge t gives rk_valid=1 with K10 after edge t+11.
- Throughput: one key per cycle while rk_ready is held 1, so a full forward or reverse sequence takes 11 consecutive cycles in SERVE.
- Backpressure: while rk_valid && !rk_ready, rk and rk_idx hold stable and no step is applied.
- done asserts in the cycle after the final handshake. busy drops in the cycle after done.
- start is ignored while busy=1. key and dir are not required to be held after start.
- start and reset asserted together: reset wins.

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs read 0 immediately and stay 0; start after release is honoured.
- Forward vector (FIPS-197 A.1):
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, dir=0, rk_ready=1.
  - K0 = key at start+1.
  - K1 = a0fafe1788542cb123a339392a6c7605.
  - K10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at start+11.
  - done at start+12.
- Reverse vector:
  - Stimulus: same key, dir=1.
  - rk_valid first rises at start+11 with rk_idx=10, rk=d014f9a8…0ca6.
  - Keys then arrive in order idx 9..0, with K1=a0fafe17…7605 and K0=2b7e1516…4f3c.
  - done follows the idx-0 handshake.
- Backpressure: dir=0, rk_ready toggled randomly → the accepted sequence is identical to the unthrottled one, and rk holds stable while stalled.
- Start while busy: pulse start with a different key mid-SERVE → ignored; the original sequence completes unchanged.
- Back-to-back: start asserted in the cycle after done drops busy → the second run's first key appears with normal latency and no carry-over of r.
